// File: rtl/fp_arbiter.sv
// Round-robin arbiter sharing one combinational fp unit between two requesters.
// Operands are registered and held FP_LAT cycles before the result is captured.
module fp_arbiter #(
    parameter int FP_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid0,
    input  logic        req_valid1,
    output logic        req_ready0,
    output logic        req_ready1,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    input  logic        req_op0,
    input  logic        req_op1,
    output logic        resp_valid0,
    output logic        resp_valid1,
    input  logic        resp_ready0,
    input  logic        resp_ready1,
    output logic [31:0] resp_result,
    output logic [31:0] fp_a,
    output logic [31:0] fp_b,
    output logic        fp_ALUControl,
    input  logic [31:0] fp_Result,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_LAST = 4'(FP_LAT - 1);

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        owner_q, owner_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] fp_a_q, fp_a_d;
    logic [31:0] fp_b_q, fp_b_d;
    logic        op_q, op_d;
    logic [31:0] result_q, result_d;
    logic        grant0, grant1;

    // Grant is only meaningful in IDLE; prio breaks ties between two valid requests.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            if (req_valid0 && req_valid1) begin
                grant0 = ~prio_q;
                grant1 = prio_q;
            end else begin
                grant0 = req_valid0;
                grant1 = req_valid1;
            end
        end
    end

    assign req_ready0 = grant0 & ~reset;
    assign req_ready1 = grant1 & ~reset;

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        fp_a_d   = fp_a_q;
        fp_b_d   = fp_b_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    fp_a_d  = grant1 ? req_a1  : req_a0;
                    fp_b_d  = grant1 ? req_b1  : req_b0;
                    op_d    = grant1 ? req_op1 : req_op0;
                    owner_d = grant1;
                    prio_d  = ~grant1;
                    cnt_d   = 4'd0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    result_d = fp_Result;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (owner_q ? resp_ready1 : resp_ready0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            cnt_q    <= 4'd0;
            fp_a_q   <= 32'h0;
            fp_b_q   <= 32'h0;
            op_q     <= 1'b0;
            result_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            fp_a_q   <= fp_a_d;
            fp_b_q   <= fp_b_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign fp_a          = fp_a_q;
    assign fp_b          = fp_b_q;
    assign fp_ALUControl = op_q;
    assign resp_result   = result_q;
    assign resp_valid0   = (state_q == RESP) & ~owner_q;
    assign resp_valid1   = (state_q == RESP) &  owner_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_fp_arbiter.sv
// Bench for fp_arbiter: instance 0 uses FP_LAT=1, instance 1 uses FP_LAT=3.
// Expected responses are queued at stimulus time and popped by a negedge monitor.
module tb_fp_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  rv0, rv1, op0, op1, rr0, rr1, rq0, rq1, vs0, vs1, fop, bsy;
    logic [31:0] a0 [2];
    logic [31:0] b0 [2];
    logic [31:0] a1 [2];
    logic [31:0] b1 [2];
    logic [31:0] res [2];
    logic [31:0] fa [2];
    logic [31:0] fb [2];
    logic [31:0] fres [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc [2];
    int last_acc [2];
    logic [1:0] chk_space;
    logic [32:0] expq1 [$];
    logic [32:0] expq3 [$];

    // Stand-in for the fp unit: hand-known IEEE-754 results for the directed vectors.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        case ({op, a, b})
            {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
            {1'b0, 32'h40000000, 32'h3F800000}: return 32'h40400000;
            {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {1'b1, 32'h40000000, 32'h40400000}: return 32'h40C00000;
            default: return a ^ b ^ 32'h5A5A0000;
        endcase
    endfunction

    fp_arbiter #(.FP_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid0(rv0[0]), .req_valid1(rv1[0]), .req_ready0(rq0[0]), .req_ready1(rq1[0]),
        .req_a0(a0[0]), .req_b0(b0[0]), .req_a1(a1[0]), .req_b1(b1[0]),
        .req_op0(op0[0]), .req_op1(op1[0]),
        .resp_valid0(vs0[0]), .resp_valid1(vs1[0]), .resp_ready0(rr0[0]), .resp_ready1(rr1[0]),
        .resp_result(res[0]), .fp_a(fa[0]), .fp_b(fb[0]), .fp_ALUControl(fop[0]),
        .fp_Result(fres[0]), .busy(bsy[0])
    );

    fp_arbiter #(.FP_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid0(rv0[1]), .req_valid1(rv1[1]), .req_ready0(rq0[1]), .req_ready1(rq1[1]),
        .req_a0(a0[1]), .req_b0(b0[1]), .req_a1(a1[1]), .req_b1(b1[1]),
        .req_op0(op0[1]), .req_op1(op1[1]),
        .resp_valid0(vs0[1]), .resp_valid1(vs1[1]), .resp_ready0(rr0[1]), .resp_ready1(rr1[1]),
        .resp_result(res[1]), .fp_a(fa[1]), .fp_b(fb[1]), .fp_ALUControl(fop[1]),
        .fp_Result(fres[1]), .busy(bsy[1])
    );

    assign fres[0] = fp_model(fa[0], fb[0], fop[0]);
    assign fres[1] = fp_model(fa[1], fb[1], fop[1]);

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, req, $time);
        end
    endtask

    // Monitor: handshakes, exclusivity, accept spacing and scoreboard pops.
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset === 1'b0) begin
            for (int k = 0; k < 2; k++) begin
                if (vs0[k] | vs1[k]) chk("resp_valid_excl", {32'b0, vs0[k] & vs1[k]}, 33'd0);
                if (rq0[k] | rq1[k]) chk("grant_excl", {32'b0, rq0[k] & rq1[k]}, 33'd0);
                if ((rv0[k] & rq0[k]) | (rv1[k] & rq1[k])) begin
                    if (chk_space[k] && acc[k] > 0) chk("accept_spacing", 33'(cyc - last_acc[k]), 33'd3);
                    acc[k]++;
                    last_acc[k] = cyc;
                end
                if ((vs0[k] & rr0[k]) | (vs1[k] & rr1[k])) begin
                    if ((k == 0 && expq1.size() == 0) || (k == 1 && expq3.size() == 0)) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_resp inst=%0d actual=%h required=none", k, {vs1[k], res[k]});
                    end else begin
                        if (k == 0) e = expq1.pop_front();
                        else        e = expq3.pop_front();
                        chk("resp_req_result", {vs1[k], res[k]}, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int k);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = ((k == 0) ? (expq1.size() == 0) : (expq3.size() == 0)) && !bsy[k];
        end
        chk("drain", {32'b0, done}, 33'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        reset = 1'b1;
        rv0 = '0; rv1 = '0; op0 = '0; op1 = '0; rr0 = '0; rr1 = '0;
        chk_space = '0;
        for (int k = 0; k < 2; k++) begin
            a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
            acc[k] = 0; last_acc[k] = 0;
        end

        // Reset with requester 0 already pending; doubles as single add on FP_LAT=1.
        rv0[0] = 1'b1; a0[0] = 32'h3F800000; b0[0] = 32'h40000000; op0[0] = 1'b0; rr0[0] = 1'b1;
        expq1.push_back({1'b0, 32'h40400000});
        @(negedge clk);
        chk("rst_ready0", {32'b0, rq0[0]}, 33'd0);
        chk("rst_flags", {25'b0, bsy, vs0, vs1, fop}, 33'd0);
        chk("rst_fa_fb", {1'b0, fa[0] | fb[0] | fa[1] | fb[1]}, 33'd0);
        chk("rst_result", {1'b0, res[0] | res[1]}, 33'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready0", {31'b0, rq0[0], bsy[0]}, 33'b10);
        tick();
        rv0[0] = 1'b0;
        @(negedge clk);
        chk("exec_state", {31'b0, bsy[0], vs0[0]}, 33'b10);
        chk("exec_fa", {1'b0, fa[0]}, {1'b0, 32'h3F800000});
        chk("exec_fb", {1'b0, fb[0]}, {1'b0, 32'h40000000});
        @(negedge clk);
        chk("add_valid", {32'b0, vs0[0]}, 33'd1);
        chk("add_result", {1'b0, res[0]}, {1'b0, 32'h40400000});
        @(negedge clk);
        chk("add_one_cycle", {31'b0, vs0[0], bsy[0]}, 33'd0);

        // Requester 1 alone leaves prio at 0 for the contention run.
        tick();
        rv1[0] = 1'b1; a1[0] = 32'h3F800000; b1[0] = 32'h40000000; op1[0] = 1'b0; rr1[0] = 1'b1;
        expq1.push_back({1'b1, 32'h40400000});
        @(negedge clk);
        chk("solo1_ready", {32'b0, rq1[0]}, 33'd1);
        tick();
        rv1[0] = 1'b0;
        wait_drain(0);

        // Sustained contention: 0,1,0,1 with minimum spacing.
        tick();
        rv0[0] = 1'b1; a0[0] = 32'h40000000; b0[0] = 32'h40400000; op0[0] = 1'b1;
        rv1[0] = 1'b1; a1[0] = 32'h3F800000; b1[0] = 32'h3F800000; op1[0] = 1'b0;
        rr0[0] = 1'b1; rr1[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expq1.push_back({1'b0, 32'h40C00000});
            expq1.push_back({1'b1, 32'h40000000});
        end
        acc[0] = 0;
        chk_space[0] = 1'b1;
        for (int i = 0; i < 100 && acc[0] < 4; i++) tick();
        rv0[0] = 1'b0; rv1[0] = 1'b0;
        chk_space[0] = 1'b0;
        chk("contention_accepts", 33'(acc[0]), 33'd4);
        wait_drain(0);

        // Backpressure on FP_LAT=3 with requester 0 pending.
        tick();
        rv1[1] = 1'b1; a1[1] = 32'h3F800000; b1[1] = 32'h3F800000; op1[1] = 1'b0; rr1[1] = 1'b0;
        expq3.push_back({1'b1, 32'h40000000});
        @(negedge clk);
        chk("bp_ready1", {32'b0, rq1[1]}, 33'd1);
        tick();
        rv1[1] = 1'b0;
        rv0[1] = 1'b1; a0[1] = 32'h3F800000; b0[1] = 32'h40000000; op0[1] = 1'b0; rr0[1] = 1'b1;
        expq3.push_back({1'b0, 32'h40400000});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lat3_exec", {31'b0, vs1[1], rq0[1]}, 33'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {30'b0, vs1[1], bsy[1], rq0[1]}, 33'b110);
            chk("bp_result", {1'b0, res[1]}, {1'b0, 32'h40000000});
        end
        tick();
        rr1[1] = 1'b1;
        @(negedge clk);
        chk("bp_release", {31'b0, vs1[1], rq0[1]}, 33'b10);
        tick();
        @(negedge clk);
        chk("bp_next_accept", {31'b0, rq0[1], vs1[1]}, 33'b10);
        tick();
        rv0[1] = 1'b0;
        wait_drain(1);

        // Operand isolation: requester inputs churn during EXEC.
        tick();
        rv0[1] = 1'b1; a0[1] = 32'h3F800000; b0[1] = 32'h3F800000; op0[1] = 1'b0;
        expq3.push_back({1'b0, 32'h40000000});
        @(negedge clk);
        chk("iso_ready0", {32'b0, rq0[1]}, 33'd1);
        tick();
        rv0[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            a0[1] = $urandom; b0[1] = $urandom; op0[1] = ~op0[1];
            @(negedge clk);
            chk("iso_fa", {1'b0, fa[1]}, {1'b0, 32'h3F800000});
            chk("iso_fb_op", {fop[1], fb[1]}, {1'b0, 32'h3F800000});
        end
        wait_drain(1);

        // Reset during EXEC discards the operation and restores prio.
        tick();
        rv0[1] = 1'b1; a0[1] = 32'h40000000; b0[1] = 32'h40400000; op0[1] = 1'b1;
        @(negedge clk);
        chk("mid_ready0", {32'b0, rq0[1]}, 33'd1);
        tick();
        rv0[1] = 1'b0;
        @(negedge clk);
        chk("mid_busy", {32'b0, bsy[1]}, 33'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_fa_fb", {1'b0, fa[1] | fb[1]}, 33'd0);
        chk("mid_rst_flags", {31'b0, bsy[1], vs0[1]}, 33'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_no_resp", {31'b0, vs0[1], vs1[1]}, 33'd0);
        end
        tick();
        rv0[1] = 1'b1; a0[1] = 32'h3F800000; b0[1] = 32'h40000000; op0[1] = 1'b0;
        rv1[1] = 1'b1; a1[1] = 32'h3F800000; b1[1] = 32'h3F800000; op1[1] = 1'b0;
        rr0[1] = 1'b1; rr1[1] = 1'b1;
        expq3.push_back({1'b0, 32'h40400000});
        expq3.push_back({1'b1, 32'h40000000});
        a = acc[1];
        @(negedge clk);
        chk("prio_after_reset", {31'b0, rq0[1], rq1[1]}, 33'b10);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (acc[1] >= a + 1) rv0[1] = 1'b0;
            if (acc[1] >= a + 2) begin
                rv1[1] = 1'b0;
                break;
            end
        end
        chk("fresh_accepts", 33'(acc[1] - a), 33'd2);
        wait_drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
